// File: rtl/vpu_pkg.sv
// Shared definitions for the CPU/VPU memory bus arbiter.
package vpu_pkg;

  // Bus ownership phases; encodings kept identical to the legacy values.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_VPU_OWN  = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_t;

  // Default cycles to wait for cpu_ba before forcing the grant.
  localparam int unsigned BA_TIMEOUT_DEF = 8;

  // Default width of the stolen-cycle counter.
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/vram_bus_arbiter.sv
// Shares the 64K system memory bus between the CPU and the video DMA engine.
// The VPU requests the bus with vpu_hold; the CPU is halted, and the bus is
// handed over once the CPU reports bus-available (or after a timeout).
// A mandatory dead cycle separates VPU ownership from CPU ownership.
module vram_bus_arbiter
  import vpu_pkg::*;
#(
  parameter int unsigned BA_TIMEOUT = BA_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_dout,
  output logic [7:0]       cpu_din,
  input  logic             cpu_rw,
  input  logic             cpu_vma,
  output logic             cpu_halt,
  input  logic             cpu_ba,
  input  logic             vpu_hold,
  input  logic [15:0]      vpu_addr,
  input  logic             vpu_vramcs,
  output logic             vpu_grant,
  output logic [7:0]       vpu_data,
  output logic [15:0]      mem_addr,
  output logic [7:0]       mem_dout,
  input  logic [7:0]       mem_din,
  output logic             mem_cs,
  output logic             mem_we,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stolen_cnt,
  output logic             ba_timeout
);

  localparam int unsigned TMR_W = $clog2(BA_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BA_TIMEOUT - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             force_grant;

  // State and bus-available wait timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state logic: request, wait for cpu_ba (or time out), own, release.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    force_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vpu_hold) begin
          state_nxt = ST_HALT_REQ;
          timer_nxt = '0;
        end
      end
      ST_HALT_REQ: begin
        if (!vpu_hold) begin
          state_nxt = ST_RELEASE;
        end else if (cpu_ba) begin
          state_nxt = ST_VPU_OWN;
        end else if (timer == TMR_LAST) begin
          state_nxt   = ST_VPU_OWN;
          force_grant = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_VPU_OWN: begin
        if (!vpu_hold) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Owner mux and handshake outputs. cpu_halt/vpu_grant are decoded from the
  // state register, which gives the same timing as the legacy registered
  // flags and drops cpu_halt during the dead cycle and on async reset.
  always_comb begin
    cpu_halt  = (state == ST_HALT_REQ) || (state == ST_VPU_OWN);
    vpu_grant = (state == ST_VPU_OWN);
    mem_addr  = cpu_addr;
    mem_cs    = cpu_vma;
    mem_we    = cpu_vma & ~cpu_rw;
    mem_dout  = cpu_dout;
    case (state)
      ST_VPU_OWN: begin
        mem_addr = vpu_addr;
        mem_cs   = vpu_vramcs;
        mem_we   = 1'b0;
        mem_dout = '0;
      end
      ST_RELEASE: begin
        mem_addr = vpu_addr;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_dout = '0;
      end
      default: begin
      end
    endcase
  end

  assign cpu_din = mem_din;

  // Fetch data capture and diagnostic counters; clr_stats beats any update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpu_data   <= '0;
      stolen_cnt <= '0;
      ba_timeout <= 1'b0;
    end else begin
      if ((state == ST_VPU_OWN) && vpu_vramcs) begin
        vpu_data <= mem_din;
      end
      if (clr_stats) begin
        stolen_cnt <= '0;
        ba_timeout <= 1'b0;
      end else begin
        if ((state == ST_VPU_OWN) && (stolen_cnt != '1)) begin
          stolen_cnt <= stolen_cnt + CNT_W'(1);
        end
        if (force_grant) begin
          ba_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Self-checking bench for vram_bus_arbiter: directed vector tables, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_vram_bus_arbiter;

  localparam int unsigned BA_TO = 8;
  localparam int unsigned CW    = 16;
  localparam int          MAXC  = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   cpu_addr = '0;
  logic [7:0]    cpu_dout = '0;
  logic [7:0]    cpu_din;
  logic          cpu_rw = 1'b1;
  logic          cpu_vma = 1'b0;
  logic          cpu_halt;
  logic          cpu_ba = 1'b0;
  logic          vpu_hold = 1'b0;
  logic [15:0]   vpu_addr = '0;
  logic          vpu_vramcs = 1'b0;
  logic          vpu_grant;
  logic [7:0]    vpu_data;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din = '0;
  logic          mem_cs;
  logic          mem_we;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] stolen_cnt;
  logic          ba_timeout;

  int errors = 0;
  int checks = 0;

  vram_bus_arbiter #(.BA_TIMEOUT(BA_TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_rw(cpu_rw), .cpu_vma(cpu_vma), .cpu_halt(cpu_halt), .cpu_ba(cpu_ba),
    .vpu_hold(vpu_hold), .vpu_addr(vpu_addr), .vpu_vramcs(vpu_vramcs),
    .vpu_grant(vpu_grant), .vpu_data(vpu_data),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .clr_stats(clr_stats), .stolen_cnt(stolen_cnt), .ba_timeout(ba_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle grant sequence vectors.
  typedef struct {
    logic        hold, ba, vcs, vma, rw;
    logic [15:0] vaddr;
    logic [7:0]  din;
    logic        e_halt, e_grant, e_cs, e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_vdata;
  } seq_row_t;

  // CPU passthrough vectors.
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw, vma;
    logic [7:0]  din;
    logic        e_cs, e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
  } cpu_row_t;

  seq_row_t seq[8];
  cpu_row_t cpu_vec[5];

  // Behavioural model state for the random run.
  bit         m_halted, m_owned, m_dead, m_to;
  int         m_wait, m_stolen;
  logic [7:0] m_vdata;

  initial begin
    //                hold ba vcs vma rw  vaddr     din    halt grant cs we  addr      vdata
    seq[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00};
    seq[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h00};
    seq[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00};
    seq[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 8'h00};
    seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4001, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4001, 8'hA5};
    seq[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4002, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4002, 8'hA5};
    seq[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4003, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4003, 8'hA5};
    seq[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4003, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 8'hA5};

    //                    addr      dout   rw    vma   din    cs    we    addr      dout
    cpu_vec[0] = '{16'h0123, 8'h5A, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 16'h0123, 8'h5A};
    cpu_vec[1] = '{16'h0123, 8'h5A, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 16'h0123, 8'h5A};
    cpu_vec[2] = '{16'hBEEF, 8'hC3, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 16'hBEEF, 8'hC3};
    cpu_vec[3] = '{16'hFFFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 8'hFF};
    cpu_vec[4] = '{16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00};

    // Reset held with a pending hold request.
    rst = 1'b0; vpu_hold = 1'b1; cpu_vma = 1'b0; cpu_addr = 16'h0123;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_halt", cpu_halt, 0);
    chk("rst_grant", vpu_grant, 0);
    chk("rst_vdata", vpu_data, 0);
    chk("rst_stolen", stolen_cnt, 0);
    chk("rst_timeout", ba_timeout, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    rst = 1'b1;
    #1;
    chk("rst_rel_idle", cpu_halt, 0);
    tick();
    chk("rst_rel_halt", cpu_halt, 1);
    chk("rst_rel_grant", vpu_grant, 0);
    vpu_hold = 1'b0;
    tick();
    tick();

    // Normal grant sequence.
    for (int i = 0; i < 8; i++) begin
      vpu_hold = seq[i].hold; cpu_ba = seq[i].ba; vpu_vramcs = seq[i].vcs;
      cpu_vma = seq[i].vma; cpu_rw = seq[i].rw; vpu_addr = seq[i].vaddr;
      mem_din = seq[i].din;
      #1;
      chk($sformatf("seq%0d_halt", i), cpu_halt, seq[i].e_halt);
      chk($sformatf("seq%0d_grant", i), vpu_grant, seq[i].e_grant);
      chk($sformatf("seq%0d_cs", i), mem_cs, seq[i].e_cs);
      chk($sformatf("seq%0d_we", i), mem_we, seq[i].e_we);
      chk($sformatf("seq%0d_addr", i), mem_addr, seq[i].e_addr);
      chk($sformatf("seq%0d_vdata", i), vpu_data, seq[i].e_vdata);
      tick();
    end
    chk("seq_stolen", stolen_cnt, 3);
    chk("seq_timeout", ba_timeout, 0);
    cpu_vma = 1'b0; cpu_ba = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("seq_clr", stolen_cnt, 0);

    // CPU passthrough while idle.
    for (int i = 0; i < 5; i++) begin
      cpu_addr = cpu_vec[i].addr; cpu_dout = cpu_vec[i].dout;
      cpu_rw = cpu_vec[i].rw; cpu_vma = cpu_vec[i].vma; mem_din = cpu_vec[i].din;
      #1;
      chk($sformatf("cpu%0d_cs", i), mem_cs, cpu_vec[i].e_cs);
      chk($sformatf("cpu%0d_we", i), mem_we, cpu_vec[i].e_we);
      chk($sformatf("cpu%0d_addr", i), mem_addr, cpu_vec[i].e_addr);
      chk($sformatf("cpu%0d_dout", i), mem_dout, cpu_vec[i].e_dout);
      chk($sformatf("cpu%0d_din", i), cpu_din, cpu_vec[i].din);
      tick();
    end
    cpu_vma = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0123;

    // cpu_ba ignored in idle; forced grant after eight waiting cycles.
    cpu_ba = 1'b1;
    tick();
    chk("ba_idle_halt", cpu_halt, 0);
    cpu_ba = 1'b0;
    vpu_hold = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("to_wait%0d_grant", i), vpu_grant, 0);
    end
    chk("to_pre_flag", ba_timeout, 0);
    tick();
    chk("to_grant", vpu_grant, 1);
    chk("to_flag", ba_timeout, 1);
    vpu_hold = 1'b0;
    tick();
    tick();
    chk("to_sticky", ba_timeout, 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("to_clr", ba_timeout, 0);

    // Hold withdrawn before grant: straight to the dead cycle, no VPU access.
    vpu_hold = 1'b1;
    tick();
    vpu_hold = 1'b0; vpu_vramcs = 1'b1; cpu_vma = 1'b1;
    tick();
    chk("abort_halt", cpu_halt, 0);
    chk("abort_grant", vpu_grant, 0);
    chk("abort_cs", mem_cs, 0);
    tick();
    chk("abort_stolen", stolen_cnt, 0);
    vpu_vramcs = 1'b0; cpu_vma = 1'b0;

    // Release then immediate re-request: one dead cycle, then idle, then request.
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    tick();
    tick();
    chk("rr_grant", vpu_grant, 1);
    vpu_hold = 1'b0;
    tick();
    vpu_hold = 1'b1; cpu_vma = 1'b1; cpu_rw = 1'b0; cpu_ba = 1'b0;
    #1;
    chk("rr_rel_halt", cpu_halt, 0);
    chk("rr_rel_grant", vpu_grant, 0);
    chk("rr_rel_cs", mem_cs, 0);
    tick();
    chk("rr_idle_halt", cpu_halt, 0);
    chk("rr_idle_cs", mem_cs, 1);
    tick();
    chk("rr_req_halt", cpu_halt, 1);
    chk("rr_req_grant", vpu_grant, 0);
    vpu_hold = 1'b0; cpu_vma = 1'b0; cpu_rw = 1'b1;
    tick();
    tick();

    // Asynchronous reset while the VPU owns the bus.
    vpu_hold = 1'b1; cpu_ba = 1'b1; cpu_vma = 1'b1; vpu_addr = 16'h7777;
    tick();
    tick();
    chk("ar_pre_grant", vpu_grant, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_halt", cpu_halt, 0);
    chk("ar_grant", vpu_grant, 0);
    chk("ar_addr", mem_addr, 16'h0123);
    chk("ar_cs", mem_cs, 1);
    vpu_hold = 1'b0; cpu_vma = 1'b0; cpu_ba = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Stolen-cycle counter: count, saturate, clear while still owning.
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    tick();
    tick();
    chk("cnt_start", stolen_cnt, 0);
    repeat (40) tick();
    chk("cnt_40", stolen_cnt, 40);
    repeat (65534 - 40) tick();
    chk("cnt_fffe", stolen_cnt, 16'hFFFE);
    repeat (5) tick();
    chk("cnt_sat", stolen_cnt, 16'hFFFF);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("cnt_clr_wins", stolen_cnt, 0);
    tick();
    chk("cnt_after_clr", stolen_cnt, 1);
    vpu_hold = 1'b0; cpu_ba = 1'b0;
    tick();
    tick();

    // Randomized run against the behavioural model, starting from reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_halted = 0; m_owned = 0; m_dead = 0; m_to = 0;
    m_wait = 0; m_stolen = 0; m_vdata = '0;
    for (int n = 0; n < 3000; n++) begin
      logic        e_cs, e_we;
      logic [15:0] e_addr;
      logic [7:0]  e_dout;
      if ($urandom_range(0, 5) == 0) vpu_hold = ~vpu_hold;
      cpu_ba     = ($urandom_range(0, 9) == 0);
      clr_stats  = ($urandom_range(0, 49) == 0);
      vpu_vramcs = 1'($urandom);
      cpu_vma    = 1'($urandom);
      cpu_rw     = 1'($urandom);
      cpu_addr   = 16'($urandom);
      vpu_addr   = 16'($urandom);
      cpu_dout   = 8'($urandom);
      mem_din    = 8'($urandom);
      if (m_owned) begin
        e_addr = vpu_addr; e_cs = vpu_vramcs; e_we = 1'b0; e_dout = 8'h00;
      end else if (m_dead) begin
        e_addr = vpu_addr; e_cs = 1'b0; e_we = 1'b0; e_dout = 8'h00;
      end else begin
        e_addr = cpu_addr; e_cs = cpu_vma; e_we = cpu_vma & ~cpu_rw; e_dout = cpu_dout;
      end
      #1;
      chk("rnd_halt", cpu_halt, m_halted);
      chk("rnd_grant", vpu_grant, m_owned);
      chk("rnd_cs", mem_cs, e_cs);
      chk("rnd_we", mem_we, e_we);
      chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_dout", mem_dout, e_dout);
      chk("rnd_din", cpu_din, mem_din);
      chk("rnd_vdata", vpu_data, m_vdata);
      chk("rnd_stolen", stolen_cnt, m_stolen);
      chk("rnd_timeout", ba_timeout, m_to);
      @(posedge clk);
      if (m_dead) begin
        m_dead = 0;
      end else if (m_owned) begin
        if (vpu_vramcs) m_vdata = mem_din;
        if (!clr_stats) m_stolen = (m_stolen + 1 > MAXC) ? MAXC : m_stolen + 1;
        if (!vpu_hold) begin
          m_owned = 0; m_halted = 0; m_dead = 1;
        end
      end else if (m_halted) begin
        if (!vpu_hold) begin
          m_halted = 0; m_dead = 1;
        end else if (cpu_ba) begin
          m_owned = 1;
        end else begin
          m_wait++;
          if (m_wait == BA_TO) begin
            m_owned = 1;
            if (!clr_stats) m_to = 1;
          end
        end
      end else if (vpu_hold) begin
        m_halted = 1; m_wait = 0;
      end
      if (clr_stats) begin
        m_stolen = 0; m_to = 0;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
